// File: rtl/z80_bus_arbiter_pkg.sv
// z80_bus_arbiter_pkg: shared bus widths, arbiter FSM states and bus-mux select codes
// Contents:
//   ADDR_W / DATA_W  - system bus address and data widths
//   CNT_W            - width of the burst and hold counters
//   state_t          - S_RST, S_CPU, S_DMA, S_HOLD
//   SEL_CPU/SEL_DMA  - bus_mux select values
package z80_bus_arbiter_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int CNT_W = 4;
    typedef enum logic [1:0] {S_RST, S_CPU, S_DMA, S_HOLD} state_t;
    localparam logic SEL_CPU = 1'b0;
    localparam logic SEL_DMA = 1'b1;
endpackage

// File: rtl/z80_bus_arbiter_bus_mux.sv
// z80_bus_arbiter_bus_mux: combinational 2:1 select of the RAM address/we/wdata between core and DMA
// Ports:
//   sel                                  - SEL_CPU or SEL_DMA
//   cpu_address, cpu_we, cpu_wdata       - core side
//   dma_address, dma_we, dma_wdata       - DMA side
//   address, we, wdata                   - selected master (write enable not yet gated)
module z80_bus_arbiter_bus_mux
    import z80_bus_arbiter_pkg::*;
(
    input  logic              sel,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [ADDR_W-1:0] dma_address,
    input  logic              dma_we,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [ADDR_W-1:0] address,
    output logic              we,
    output logic [DATA_W-1:0] wdata
);
    assign address = (sel == SEL_DMA) ? dma_address : cpu_address;
    assign we      = (sel == SEL_DMA) ? dma_we : cpu_we;
    assign wdata   = (sel == SEL_DMA) ? dma_wdata : cpu_wdata;
endmodule

// File: rtl/z80_bus_arbiter.sv
// z80_bus_arbiter: shares single-port RAM between the z80 core and one DMA master, stalling the
// core through cpu_ce while DMA owns the bus and bounding DMA bursts to MAX_BURST transfers,
// after which the core gets at least CPU_MIN cycles.
// Ports:
//   clock, reset                              - posedge clock, synchronous active-high reset
//   cpu_address/cpu_we/cpu_data_o/cpu_data_i  - core bus; cpu_ce stalls the core when low
//   dma_req/dma_address/dma_we/dma_wdata      - DMA request, held until dma_gnt & dma_req
//   dma_gnt/dma_rdata                         - DMA owns the bus this cycle / read data
//   mem_address/mem_we/mem_wdata/mem_rdata    - RAM port (same-cycle read)
//   stall_cnt                                 - core stall cycles, only with ARB_STATS_EN defined
// Configuration: define ARB_STATS_EN to build the saturating stall counter; otherwise it reads 0.
module z80_bus_arbiter
    import z80_bus_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CPU_MIN = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_data_o,
    output logic [DATA_W-1:0] cpu_data_i,
    output logic              cpu_ce,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_address,
    input  logic              dma_we,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       stall_cnt
);
    localparam logic [CNT_W-1:0] MB = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CM = CNT_W'(CPU_MIN);

    state_t state, state_n;
    logic [CNT_W-1:0] burst, burst_n, hold, hold_n;
    logic [CNT_W-1:0] burst_inc, hold_inc;
    logic sel, we_en, mux_we;

    assign burst_inc = burst + 1'b1;
    assign hold_inc = hold + 1'b1;

    always_comb begin
        state_n = state;
        burst_n = burst;
        hold_n = hold;
        sel = SEL_CPU;
        we_en = 1'b0;
        case (state)
            S_RST: state_n = S_CPU;
            S_CPU: begin
                we_en = 1'b1;
                if (dma_req) begin
                    state_n = S_DMA;
                    burst_n = '0;
                end
            end
            S_DMA: begin
                sel = SEL_DMA;
                // a dropped request turns this cycle into a bubble: no RAM write
                we_en = dma_req;
                if (dma_req) begin
                    burst_n = burst_inc;
                    if (burst_inc == MB) begin
                        state_n = S_HOLD;
                        hold_n = '0;
                    end
                end else begin
                    state_n = S_CPU;
                end
            end
            S_HOLD: begin
                we_en = 1'b1;
                hold_n = hold_inc;
                if (hold_inc == CM) begin
                    state_n = dma_req ? S_DMA : S_CPU;
                    if (dma_req) burst_n = '0;
                end
            end
            default: state_n = S_RST;
        endcase
    end

    // cpu_ce/dma_gnt are registered from the next state so they switch only on cycle boundaries
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_RST;
            cpu_ce <= 1'b0;
            dma_gnt <= 1'b0;
            burst <= '0;
            hold <= '0;
        end else begin
            state <= state_n;
            cpu_ce <= (state_n == S_CPU) || (state_n == S_HOLD);
            dma_gnt <= (state_n == S_DMA);
            burst <= burst_n;
            hold <= hold_n;
        end
    end

    z80_bus_arbiter_bus_mux u_bus_mux (
        .sel        (sel),
        .cpu_address(cpu_address),
        .cpu_we     (cpu_we),
        .cpu_wdata  (cpu_data_o),
        .dma_address(dma_address),
        .dma_we     (dma_we),
        .dma_wdata  (dma_wdata),
        .address    (mem_address),
        .we         (mux_we),
        .wdata      (mem_wdata)
    );

    assign mem_we = mux_we & we_en;
    assign cpu_data_i = mem_rdata;
    assign dma_rdata = mem_rdata;

`ifdef ARB_STATS_EN
    // the core is stalled exactly in cycles with cpu_ce low; the post-reset S_RST cycle is not a stall
    always_ff @(posedge clock) begin
        if (reset) stall_cnt <= '0;
        else if (!cpu_ce && state != S_RST && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
    end
`else
    assign stall_cnt = 16'h0000;
`endif
endmodule
